priority_encoder_stream: RTL and testbench

PRIORITY_ENCODER_STREAM -- requirements
Module: priority_encoder_stream

---
 rtl/priority_encoder_pkg.sv | 19 +
 rtl/pe_find_first.sv | 62 ++++++
 rtl/priority_encoder_stream.sv | 131 +++++++++++++
 tb/tb_priority_encoder_stream.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_pkg.sv
// Shared types and helpers for the streaming priority encoder.
package priority_encoder_pkg;

    // IDLE: no word held. RUN: bits left to emit, or a zero-word beat pending.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pe_state_e;

    // Width of a binary index into a vector of the given width (at least 1).
    function automatic int idx_width(input int width);
        if (width > 1) begin
            return $clog2(width);
        end else begin
            return 1;
        end
    endfunction

endpackage : priority_encoder_pkg

// File: rtl/pe_find_first.sv
// Combinational first-set-bit finder: returns the lowest or highest set
// bit of vec as a one-hot vector plus its binary index.
module pe_find_first
    import priority_encoder_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic             msb_first,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    logic [WIDTH-1:0] lsb_sel_s;
    logic [WIDTH-1:0] msb_sel_s;
    logic [WIDTH-1:0] onehot_s;
    logic [IDX_W-1:0] idx_s;

    // Lowest set bit via two's-complement isolation.
    always_comb begin
        lsb_sel_s = vec & (~vec + WIDTH'(1));
    end

    // Highest set bit: the last set bit seen on an ascending scan wins.
    always_comb begin
        msb_sel_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                msb_sel_s    = '0;
                msb_sel_s[i] = 1'b1;
            end else begin
                msb_sel_s = msb_sel_s;
            end
        end
    end

    // Pick the selection matching the scan direction.
    always_comb begin
        if (msb_first) begin
            onehot_s = msb_sel_s;
        end else begin
            onehot_s = lsb_sel_s;
        end
    end

    // One-hot to binary: OR together the index of every set position.
    always_comb begin
        idx_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot_s[i]) begin
                idx_s = idx_s | IDX_W'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    assign onehot = onehot_s;
    assign idx    = idx_s;

endmodule : pe_find_first

// File: rtl/priority_encoder_stream.sv
// Streaming priority encoder: accepts a word and emits one beat per set
// bit (or a single zero beat for an all-zero word), in the requested order.
// Beat outputs are derived only from registered state, never from data_i.
module priority_encoder_stream
    import priority_encoder_pkg::*;
#(
    parameter  int WIDTH         = 16,
    parameter  bit MSB_FIRST_DEF = 1'b0,
    localparam int IDX_W         = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o,
    output logic             zero_o,
    output logic             data_val_o,
    input  logic             data_ready_i
);

    pe_state_e        state_r;
    pe_state_e        state_nx_s;
    logic [WIDTH-1:0] residual_r;
    logic [WIDTH-1:0] residual_nx_s;
    logic             dir_r;
    logic             dir_nx_s;
    // Holds ready low through reset and releases it on the first edge after.
    logic             ready_en_r;

    logic [WIDTH-1:0] sel_onehot_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic [WIDTH-1:0] remain_s;
    logic             run_s;
    logic             last_s;
    logic             consume_s;
    logic             accept_s;

    pe_find_first #(
        .WIDTH (WIDTH)
    ) u_find (
        .vec       (residual_r),
        .msb_first (dir_r),
        .onehot    (sel_onehot_s),
        .idx       (sel_idx_s)
    );

    // Beat decode from the held word; a zero word in RUN leaves all selects 0.
    always_comb begin
        run_s    = (state_r == RUN);
        remain_s = residual_r & ~sel_onehot_s;
        last_s   = run_s & (remain_s == '0);
    end

    // Handshakes: a new word may enter while idle or as the last beat leaves.
    always_comb begin
        consume_s    = run_s & data_ready_i;
        data_ready_o = ready_en_r & (~run_s | (consume_s & last_s));
        accept_s     = data_val_i & data_ready_o;
    end

    // Next-state logic for the two-state controller and the held word.
    always_comb begin
        state_nx_s    = state_r;
        residual_nx_s = residual_r;
        dir_nx_s      = dir_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s    = RUN;
                    residual_nx_s = data_i;
                    dir_nx_s      = dir_i;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (accept_s) begin
                    state_nx_s    = RUN;
                    residual_nx_s = data_i;
                    dir_nx_s      = dir_i;
                end else if (consume_s && last_s) begin
                    state_nx_s    = IDLE;
                    residual_nx_s = '0;
                end else if (consume_s) begin
                    residual_nx_s = remain_s;
                end else begin
                    state_nx_s = RUN;
                end
            end
            default: begin
                state_nx_s    = IDLE;
                residual_nx_s = '0;
                dir_nx_s      = MSB_FIRST_DEF;
            end
        endcase
    end

    // State, held word, direction and ready-enable registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_r    <= IDLE;
            residual_r <= '0;
            dir_r      <= MSB_FIRST_DEF;
            ready_en_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            residual_r <= residual_nx_s;
            dir_r      <= dir_nx_s;
            ready_en_r <= 1'b1;
        end
    end

    // Beat outputs are forced to zero outside RUN.
    always_comb begin
        data_val_o = run_s;
        last_o     = last_s;
        zero_o     = run_s & (residual_r == '0);
        if (run_s) begin
            onehot_o = sel_onehot_s;
            idx_o    = sel_idx_s;
        end else begin
            onehot_o = '0;
            idx_o    = '0;
        end
    end

endmodule : priority_encoder_stream

// File: tb/tb_priority_encoder_stream.sv
// Bench for priority_encoder_stream: directed words with literal checks,
// plus a beat-list model compared against the DUT on every falling edge.
module tb_priority_encoder_stream;

    localparam int WIDTH = 16;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             arstn_i;
    logic [WIDTH-1:0] data_i;
    logic             dir_i;
    logic             data_val_i;
    logic             data_ready_o;
    logic [WIDTH-1:0] onehot_o;
    logic [IDX_W-1:0] idx_o;
    logic             last_o;
    logic             zero_o;
    logic             data_val_o;
    logic             data_ready_i;

    int vectors     = 0;
    int miscompares = 0;

    priority_encoder_stream #(.WIDTH(WIDTH), .MSB_FIRST_DEF(1'b0)) dut (
        .clk_i        (clk),
        .arstn_i      (arstn_i),
        .data_i       (data_i),
        .dir_i        (dir_i),
        .data_val_i   (data_val_i),
        .data_ready_o (data_ready_o),
        .onehot_o     (onehot_o),
        .idx_o        (idx_o),
        .last_o       (last_o),
        .zero_o       (zero_o),
        .data_val_o   (data_val_o),
        .data_ready_i (data_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The beats still to be emitted for the held word, in emission order.
    typedef struct {
        int idx;
        bit zero;
    } beat_t;

    beat_t q[$];
    bit    en_m = 1'b0;

    function automatic void load_word(input logic [WIDTH-1:0] w, input logic d);
        beat_t b;
        q.delete();
        if (w == '0) begin
            b.idx = 0; b.zero = 1'b1; q.push_back(b);
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                int bit_pos;
                bit_pos = d ? (WIDTH - 1 - k) : k;
                if (w[bit_pos]) begin
                    b.idx = bit_pos; b.zero = 1'b0; q.push_back(b);
                end
            end
        end
    endfunction

    function automatic bit model_ready();
        return en_m && (q.size() == 0 || (data_ready_i && q.size() == 1));
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge arstn_i);
            if (!arstn_i) begin
                q.delete();
                en_m = 1'b0;
            end else begin
                bit acc;
                bit pop;
                acc = data_val_i && model_ready();
                pop = (q.size() > 0) && data_ready_i;
                if (acc) begin
                    load_word(data_i, dir_i);
                end else if (pop) begin
                    void'(q.pop_front());
                end
                en_m = 1'b1;
            end
        end
    end

    logic [WIDTH-1:0] exp_oh;

    initial begin
        forever begin
            @(negedge clk);
            if (arstn_i) begin
                check("model ready", 64'(data_ready_o), 64'(model_ready()));
                check("model valid", 64'(data_val_o), 64'(q.size() != 0));
                if (q.size() != 0) begin
                    exp_oh = q[0].zero ? 16'h0000 : (16'h0001 << q[0].idx);
                    check("model onehot", 64'(onehot_o), 64'(exp_oh));
                    check("model idx", 64'(idx_o), 64'(q[0].idx));
                    check("model last", 64'(last_o), 64'(q.size() == 1));
                    check("model zero", 64'(zero_o), 64'(q[0].zero));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive_word(input logic [WIDTH-1:0] w, input logic d);
        @(posedge clk);
        #1;
        data_i     = w;
        dir_i      = d;
        data_val_i = 1'b1;
        @(posedge clk);
        #1;
        data_val_i = 1'b0;
        data_i     = 16'hDEAD;
        dir_i      = ~d;
    endtask

    task automatic expect_beat(input string name, input int idx, input bit last, input logic [WIDTH-1:0] oh);
        @(negedge clk);
        check({name, " valid"}, 64'(data_val_o), 64'd1);
        check({name, " idx"}, 64'(idx_o), 64'(idx));
        check({name, " onehot"}, 64'(onehot_o), 64'(oh));
        check({name, " last"}, 64'(last_o), 64'(last));
        check({name, " ready"}, 64'(data_ready_o), 64'(last && data_ready_i));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " ready"}, 64'(data_ready_o), 64'd0);
        check({name, " valid"}, 64'(data_val_o), 64'd0);
        check({name, " onehot"}, 64'(onehot_o), 64'd0);
        check({name, " idx"}, 64'(idx_o), 64'd0);
        check({name, " last"}, 64'(last_o), 64'd0);
        check({name, " zero"}, 64'(zero_o), 64'd0);
    endtask

    initial begin
        arstn_i      = 1'b1;
        data_i       = 16'h0000;
        dir_i        = 1'b0;
        data_val_i   = 1'b0;
        data_ready_i = 1'b1;
        #1 arstn_i = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        arstn_i = 1'b1;
        @(posedge clk);
        #1 check("ready after release", 64'(data_ready_o), 64'd1);

        // 0x8421 LSB first
        drive_word(16'h8421, 1'b0);
        expect_beat("lsb b0", 0, 1'b0, 16'h0001);
        expect_beat("lsb b1", 5, 1'b0, 16'h0020);
        expect_beat("lsb b2", 10, 1'b0, 16'h0400);
        expect_beat("lsb b3", 15, 1'b1, 16'h8000);

        // 0x8421 MSB first
        drive_word(16'h8421, 1'b1);
        expect_beat("msb b0", 15, 1'b0, 16'h8000);
        expect_beat("msb b1", 10, 1'b0, 16'h0400);
        expect_beat("msb b2", 5, 1'b0, 16'h0020);
        expect_beat("msb b3", 0, 1'b1, 16'h0001);

        // all-zero word: one beat, then idle
        drive_word(16'h0000, 1'b0);
        expect_beat("zero beat", 0, 1'b1, 16'h0000);
        check("zero flag", 64'(zero_o), 64'd1);
        @(negedge clk);
        check("zero then idle valid", 64'(data_val_o), 64'd0);
        check("zero then idle ready", 64'(data_ready_o), 64'd1);

        // back-to-back: 0x0006 then 0x0001 offered continuously
        @(posedge clk);
        #1;
        data_i = 16'h0006; dir_i = 1'b0; data_val_i = 1'b1;
        @(posedge clk);
        #1;
        data_i = 16'h0001;
        expect_beat("b2b idx1", 1, 1'b0, 16'h0002);
        expect_beat("b2b idx2", 2, 1'b1, 16'h0004);
        @(posedge clk);
        #1 data_val_i = 1'b0;
        expect_beat("b2b idx0", 0, 1'b1, 16'h0001);

        // stall: 0x0300 with ready low for three cycles
        @(posedge clk);
        #1;
        data_i = 16'h0300; dir_i = 1'b0; data_val_i = 1'b1;
        @(posedge clk);
        #1;
        data_val_i = 1'b0; data_ready_i = 1'b0;
        expect_beat("stall 1", 8, 1'b0, 16'h0100);
        expect_beat("stall 2", 8, 1'b0, 16'h0100);
        expect_beat("stall 3", 8, 1'b0, 16'h0100);
        @(posedge clk);
        #1 data_ready_i = 1'b1;
        expect_beat("stall release", 8, 1'b0, 16'h0100);
        expect_beat("stall idx9", 9, 1'b1, 16'h0200);

        // reset in the middle of an all-ones word
        drive_word(16'hFFFF, 1'b0);
        expect_beat("ones b0", 0, 1'b0, 16'h0001);
        expect_beat("ones b1", 1, 1'b0, 16'h0002);
        expect_beat("ones b2", 2, 1'b0, 16'h0004);
        expect_beat("ones b3", 3, 1'b0, 16'h0008);
        @(posedge clk);
        #2 arstn_i = 1'b0;
        #1 check_reset_outputs("midword reset");
        @(negedge clk);
        arstn_i = 1'b1;
        @(posedge clk);
        #1 check("ready after midword reset", 64'(data_ready_o), 64'd1);
        check("no residual right after release", 64'(data_val_o), 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no residual beats", 64'(data_val_o), 64'd0);
        end

        // all-ones MSB first: sixteen beats, last only on idx 0
        drive_word(16'hFFFF, 1'b1);
        for (int k = 15; k >= 0; k--) begin
            logic [WIDTH-1:0] oh;
            oh = 16'h0001 << k;
            expect_beat("ones msb", k, (k == 0), oh);
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_priority_encoder_stream
